sprite_draw_scheduler: RTL and testbench
========================================

// Module: sprite_draw_scheduler
// PURPOSE
//  Per-frame scheduler between the sprite draw queue and two sprite blitter lanes.
//  Pops queued draw commands {id,x,y,scale} and dispatches each to a free lane.
//  Lane 0 owns sprite storage read port r0; lane 1 owns r1.
//  Tags each dispatch with a frame sequence number so downstream compositing keeps queue order.
//  Reports frame completion once the queue is drained and both lanes are idle.
// PARAMETERS
//  SPRITE_NUM   32  number of sprite slots in sprite storage; ID_W = $clog2(SPRITE_NUM)
//  MAX_SPRITES  64  dispatch cap per frame (1..255); remaining entries wait for next frame
// PORTS
//  clock          in   1     system clock (same domain as sprite_queue dequeue side)
//  reset          in   1     asynchronous, active-high
//  frame_start    in   1     one-cycle pulse: begin scheduling a frame
//  is_empty       in   1     queue empty flag
//  sprite_id      in   8     queue head: sprite id
//  sprite_x       in   16    queue head: x position
//  sprite_y       in   16    queue head: y position
//  sprite_scale   in   8     queue head: scale
//  dequeue        out  1     pop queue head at this posedge
//  lane0_start    out  1     one-cycle pulse: lane 0 command valid
//  lane0_select   out  ID_W  sprite slot for lane 0 (drives sprite_r0_select)
//  lane0_x/_y     out  16    position for lane 0
//  lane0_scale    out  8     scale for lane 0
//  lane0_seq      out  8     frame-order tag for lane 0
//  lane0_done     in   1     one-cycle pulse: lane 0 finished its sprite
//  lane1_*        —    —     identical set for lane 1 (start, select, x, y, scale, seq, done)
//  busy           out  1     state != IDLE
//  frame_done     out  1     one-cycle pulse: frame fully drawn
//  drawn_count    out  8     sprites dispatched in last completed frame
//  overrun        out  1     sticky: frame_start received while busy
//  rejected_count out  8     see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0, both lanes idle, state IDLE, seq=0, round-robin pointer=lane 0.
//  Lanes must share this reset.
//  States:
//   IDLE:  frame_start -> FETCH; seq <= 0.
//   FETCH: issue whenever !is_empty && seq<MAX_SPRITES && some lane free.
//          is_empty || seq==MAX_SPRITES -> DRAIN.
//   DRAIN: both lanes free -> DONE.
//   DONE:  frame_done=1 for one cycle; drawn_count <= seq; -> IDLE.
//  Issue (cycle t): dequeue=1 (combinational, same cycle); head fields registered into chosen lane.
//   - laneN_start=1 in cycle t+1; laneN_* fields held stable until that lane's next start.
//   - laneN_seq = seq at issue; seq increments by 1 per issue (8-bit, never exceeds MAX_SPRITES).
//   - Back-to-back issues allowed; the new queue head is valid at t+1.
//  Lane free = !laneN_busy. busy set at issue edge; cleared at edge where laneN_done=1.
//   - A lane is reissuable no earlier than the cycle after its done pulse.
//   - laneN_done while lane idle: ignored.
//  Lane choice: only one lane free -> that lane; both free -> lane != last issued (round robin).
//   Max one issue per cycle.
//  frame_start while busy: ignored; overrun <= 1 (cleared only by reset).
//  frame_start coincident with DONE: treated as overrun.
//  id width: select = sprite_id[ID_W-1:0].
//  Reset mid-frame: immediate return to IDLE; no frame_done; queue contents untouched.
// CONFIGURATION
//  SCHED_ID_CHECK_EN defined:
//   - head with sprite_id >= SPRITE_NUM is popped (dequeue=1) but not issued; seq unchanged.
//   - rejected_count += 1, saturating at 255, cleared at each IDLE->FETCH.
//  Not defined: no check, id truncated to ID_W and issued; rejected_count tied 0.
// TESTING
//  1. Queue 3 entries {id 1,2,3}, frame_start -> lanes alternate 0,1,0; seq 0,1,2;
//     done pulses -> frame_done once, drawn_count=3.
//  2. Queue empty, frame_start -> FETCH->DRAIN->DONE; frame_done 3 cycles later; drawn_count=0.
//  3. MAX_SPRITES=4, queue 6 entries -> 4 dispatched, frame_done, is_empty still 0;
//     next frame dispatches 2 with seq 0,1.
//  4. Lane 0 held busy (no done), 3 entries -> all go to lane 1 serially; each issue waits for
//     lane1_done plus 1 cycle.
//  5. frame_start mid-frame -> overrun=1, frame unaffected;
//     reset mid-FETCH -> all outputs 0, no frame_done.
//  6. SCHED_ID_CHECK_EN, SPRITE_NUM=32, ids {5,40,6} -> 40 popped, not issued;
//     rejected_count=1; drawn_count=2.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_draw_scheduler
//
// Per-frame scheduler between the sprite draw queue and two sprite blitter
// lanes. Pops draw commands {id,x,y,scale} from the queue head and dispatches
// each one to a free lane. Every dispatch is tagged with a frame sequence
// number so that downstream compositing can restore queue order. Frame
// completion is reported once the queue is drained (or the per-frame cap is
// reached) and both lanes are idle.
//
// Optional feature macro: SCHED_ID_CHECK_EN
//   defined     : heads with sprite_id >= SPRITE_NUM are popped but not
//                 issued, and counted in rejected_count (saturating, cleared
//                 when a new frame starts).
//   not defined : sprite_id is truncated to ID_W bits and always issued;
//                 rejected_count is tied to 0.
//
// Ports
//   clock, reset             system clock, asynchronous active-high reset
//   frame_start              one-cycle pulse, start scheduling a frame
//   is_empty, sprite_*       queue empty flag and queue head fields
//   dequeue                  pop the queue head at this posedge (combinational)
//   laneN_start              one-cycle pulse, lane N command valid
//   laneN_select/x/y/scale   registered command fields, held until next start
//   laneN_seq                frame-order tag of the lane N command
//   laneN_done               one-cycle pulse, lane N finished its sprite
//   busy                     scheduler not idle
//   frame_done               one-cycle pulse, frame fully drawn
//   drawn_count              sprites dispatched in the last completed frame
//   overrun                  sticky, frame_start seen while busy
//   rejected_count           out-of-range heads dropped this frame
// ---------------------------------------------------------------------------
module sprite_draw_scheduler #(
   parameter int SPRITE_NUM  = 32,
   parameter int MAX_SPRITES = 64,
   localparam int ID_W       = $clog2(SPRITE_NUM)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            frame_start,
   input  logic            is_empty,
   input  logic [7:0]      sprite_id,
   input  logic [15:0]     sprite_x,
   input  logic [15:0]     sprite_y,
   input  logic [7:0]      sprite_scale,
   output logic            dequeue,
   output logic            lane0_start,
   output logic [ID_W-1:0] lane0_select,
   output logic [15:0]     lane0_x,
   output logic [15:0]     lane0_y,
   output logic [7:0]      lane0_scale,
   output logic [7:0]      lane0_seq,
   input  logic            lane0_done,
   output logic            lane1_start,
   output logic [ID_W-1:0] lane1_select,
   output logic [15:0]     lane1_x,
   output logic [15:0]     lane1_y,
   output logic [7:0]      lane1_scale,
   output logic [7:0]      lane1_seq,
   input  logic            lane1_done,
   output logic            busy,
   output logic            frame_done,
   output logic [7:0]      drawn_count,
   output logic            overrun,
   output logic [7:0]      rejected_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] SEQ_CAP = 8'(MAX_SPRITES);

   state_t          state_r, state_s;
   logic [7:0]      seq_r;
   logic [1:0]      lane_busy_r;
   logic            rr_next_r;
   logic            overrun_r;
   logic [7:0]      drawn_count_r;
   logic [1:0]      lane_start_r;
   logic [ID_W-1:0] lane_sel_r   [2];
   logic [15:0]     lane_x_r     [2];
   logic [15:0]     lane_y_r     [2];
   logic [7:0]      lane_scale_r [2];
   logic [7:0]      lane_seq_r   [2];
   logic [1:0]      lane_done_s;
   logic            head_ok_s;
   logic            can_take_s;
   logic            pop_s;
   logic            issue_s;
   logic            issue_lane_s;
   logic            frame_begin_s;

   assign lane_done_s   = {lane1_done, lane0_done};
   assign frame_begin_s = (state_r == ST_IDLE) && frame_start;

`ifdef SCHED_ID_CHECK_EN
   assign head_ok_s = ({24'd0, sprite_id} < 32'(SPRITE_NUM));
`else
   // The upper id bits are deliberately dropped when the range check is off.
   logic unused_id_s;
   assign unused_id_s = ^sprite_id;
   assign head_ok_s   = 1'b1;
`endif

   // Issue decision, lane arbitration and next-state logic
   always_comb begin
      state_s      = state_r;
      pop_s        = 1'b0;
      issue_s      = 1'b0;
      issue_lane_s = rr_next_r;
      can_take_s   = (state_r == ST_FETCH) && !is_empty && (seq_r < SEQ_CAP);

      // Both lanes free: round robin; otherwise the single free lane.
      if (lane_busy_r == 2'b00) begin
         issue_lane_s = rr_next_r;
      end else if (lane_busy_r[0] == 1'b0) begin
         issue_lane_s = 1'b0;
      end else begin
         issue_lane_s = 1'b1;
      end

      // A rejected head is dropped even when no lane is free.
      if (can_take_s && !head_ok_s) begin
         pop_s   = 1'b1;
         issue_s = 1'b0;
      end else if (can_take_s && (lane_busy_r != 2'b11)) begin
         pop_s   = 1'b1;
         issue_s = 1'b1;
      end else begin
         pop_s   = 1'b0;
         issue_s = 1'b0;
      end

      case (state_r)
         ST_IDLE: begin
            if (frame_start) state_s = ST_FETCH;
            else             state_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (is_empty || (seq_r == SEQ_CAP)) state_s = ST_DRAIN;
            else                                state_s = ST_FETCH;
         end
         ST_DRAIN: begin
            if (lane_busy_r == 2'b00) state_s = ST_DONE;
            else                      state_s = ST_DRAIN;
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Frame state, sequence counter and frame status registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         seq_r         <= 8'd0;
         overrun_r     <= 1'b0;
         drawn_count_r <= 8'd0;
      end else begin
         state_r <= state_s;
         if (frame_begin_s) begin
            seq_r <= 8'd0;
         end else if (issue_s) begin
            seq_r <= seq_r + 8'd1;
         end
         // Also covers frame_start arriving in the DONE cycle.
         if (frame_start && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
         end
         if (state_r == ST_DONE) begin
            drawn_count_r <= seq_r;
         end
      end
   end

   // Lane command registers, start pulses, busy flags and round-robin pointer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lane_busy_r  <= 2'b00;
         lane_start_r <= 2'b00;
         rr_next_r    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            lane_sel_r[i]   <= '0;
            lane_x_r[i]     <= 16'd0;
            lane_y_r[i]     <= 16'd0;
            lane_scale_r[i] <= 8'd0;
            lane_seq_r[i]   <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (issue_s && (issue_lane_s == i[0])) begin
               lane_start_r[i] <= 1'b1;
               lane_busy_r[i]  <= 1'b1;
               lane_sel_r[i]   <= sprite_id[ID_W-1:0];
               lane_x_r[i]     <= sprite_x;
               lane_y_r[i]     <= sprite_y;
               lane_scale_r[i] <= sprite_scale;
               lane_seq_r[i]   <= seq_r;
            end else begin
               lane_start_r[i] <= 1'b0;
               // A done pulse on an idle lane simply leaves it idle.
               if (lane_done_s[i]) begin
                  lane_busy_r[i] <= 1'b0;
               end
            end
         end
         if (issue_s) begin
            rr_next_r <= ~issue_lane_s;
         end
      end
   end

`ifdef SCHED_ID_CHECK_EN
   logic [7:0] rejected_r;

   // Count dropped out-of-range heads, restarting at every new frame
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rejected_r <= 8'd0;
      end else if (frame_begin_s) begin
         rejected_r <= 8'd0;
      end else if (pop_s && !issue_s && (rejected_r != 8'hFF)) begin
         rejected_r <= rejected_r + 8'd1;
      end
   end

   assign rejected_count = rejected_r;
`else
   assign rejected_count = 8'd0;
`endif

   assign dequeue      = pop_s;
   assign busy         = (state_r != ST_IDLE);
   assign frame_done   = (state_r == ST_DONE);
   assign drawn_count  = drawn_count_r;
   assign overrun      = overrun_r;

   assign lane0_start  = lane_start_r[0];
   assign lane0_select = lane_sel_r[0];
   assign lane0_x      = lane_x_r[0];
   assign lane0_y      = lane_y_r[0];
   assign lane0_scale  = lane_scale_r[0];
   assign lane0_seq    = lane_seq_r[0];
   assign lane1_start  = lane_start_r[1];
   assign lane1_select = lane_sel_r[1];
   assign lane1_x      = lane_x_r[1];
   assign lane1_y      = lane_y_r[1];
   assign lane1_scale  = lane_scale_r[1];
   assign lane1_seq    = lane_seq_r[1];

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sprite_draw_scheduler
//
// Directed bench for sprite_draw_scheduler (SPRITE_NUM=32, MAX_SPRITES=4).
// A small queue model feeds the head fields and pops on dequeue. The basic
// three-sprite frame is a cycle-by-cycle vector table; the other scenarios
// are hand-written sequences with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_sprite_draw_scheduler;

   localparam int SPRITE_NUM  = 32;
   localparam int MAX_SPRITES = 4;
   localparam int ID_W        = 5;

   logic            clock = 1'b0;
   logic            reset;
   logic            frame_start;
   logic            is_empty;
   logic [7:0]      sprite_id;
   logic [15:0]     sprite_x;
   logic [15:0]     sprite_y;
   logic [7:0]      sprite_scale;
   logic            dequeue;
   logic            lane0_start, lane1_start;
   logic [ID_W-1:0] lane0_select, lane1_select;
   logic [15:0]     lane0_x, lane0_y, lane1_x, lane1_y;
   logic [7:0]      lane0_scale, lane0_seq, lane1_scale, lane1_seq;
   logic            lane0_done, lane1_done;
   logic            busy, frame_done, overrun;
   logic [7:0]      drawn_count, rejected_count;

   sprite_draw_scheduler #(.SPRITE_NUM(SPRITE_NUM), .MAX_SPRITES(MAX_SPRITES)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .is_empty(is_empty),
      .sprite_id(sprite_id), .sprite_x(sprite_x), .sprite_y(sprite_y),
      .sprite_scale(sprite_scale), .dequeue(dequeue),
      .lane0_start(lane0_start), .lane0_select(lane0_select), .lane0_x(lane0_x),
      .lane0_y(lane0_y), .lane0_scale(lane0_scale), .lane0_seq(lane0_seq),
      .lane0_done(lane0_done),
      .lane1_start(lane1_start), .lane1_select(lane1_select), .lane1_x(lane1_x),
      .lane1_y(lane1_y), .lane1_scale(lane1_scale), .lane1_seq(lane1_seq),
      .lane1_done(lane1_done),
      .busy(busy), .frame_done(frame_done), .drawn_count(drawn_count),
      .overrun(overrun), .rejected_count(rejected_count)
   );

   always #5 clock = ~clock;

   // queue model
   logic [7:0] q_id [0:63];
   int qh, qt;
   int checks   = 0;
   int failures = 0;

   // dispatches seen by run_frame
   logic [7:0] rec_sel [0:15];
   logic [7:0] rec_seq [0:15];
   int rec_n;

   typedef struct {
      logic       fs, d0, d1;
      logic       deq, s0, s1, bsy, fd;
      logic [7:0] sel, seq;
   } vec_t;
   vec_t vt [0:9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive_head();
      logic [7:0] id;
      id           = q_id[qh % 64];
      is_empty     = (qh == qt);
      sprite_id    = id;
      sprite_x     = {8'h10, id};
      sprite_y     = {8'h20, id};
      sprite_scale = id ^ 8'h5A;
   endtask

   task automatic push(input logic [7:0] id);
      q_id[qt % 64] = id;
      qt++;
      drive_head();
   endtask

   // One clock: pop if dequeue was high before the edge, clear pulses,
   // return at the following negedge with outputs settled.
   task automatic tick();
      logic dq;
      dq = dequeue;
      @(posedge clock);
      #1;
      if (dq) qh++;
      frame_start = 1'b0;
      lane0_done  = 1'b0;
      lane1_done  = 1'b0;
      drive_head();
      @(negedge clock);
   endtask

   task automatic record(input logic [7:0] sel, input logic [7:0] seq);
      if (rec_n < 16) begin
         rec_sel[rec_n] = sel;
         rec_seq[rec_n] = seq;
      end
      rec_n++;
   endtask

   // Start a frame, answer every lane start with a done pulse, stop after
   // frame_done (plus one cycle so drawn_count has been captured).
   task automatic run_frame(input int ovr_at);
      bit seen;
      seen        = 1'b0;
      rec_n       = 0;
      frame_start = 1'b1;
      tick();
      for (int c = 0; c < 200 && !seen; c++) begin
         if (c == ovr_at) frame_start = 1'b1;
         if (lane0_start) begin
            record({3'd0, lane0_select}, lane0_seq);
            lane0_done = 1'b1;
         end
         if (lane1_start) begin
            record({3'd0, lane1_select}, lane1_seq);
            lane1_done = 1'b1;
         end
         if (frame_done) seen = 1'b1;
         tick();
      end
      check("frame_done_seen", {31'd0, seen}, 32'd1);
   endtask

   initial begin
      int saved_qh;
      int fd_cnt;
      bit seen;

      for (int i = 0; i < 64; i++) q_id[i] = 8'd0;
      qh = 0; qt = 0;
      reset = 1'b1; frame_start = 1'b0; lane0_done = 1'b0; lane1_done = 1'b0;
      drive_head();
      @(negedge clock);
      tick();
      // reset state
      check("rst_busy",     {31'd0, busy}, 32'd0);
      check("rst_dequeue",  {31'd0, dequeue}, 32'd0);
      check("rst_drawn",    {24'd0, drawn_count}, 32'd0);
      check("rst_overrun",  {31'd0, overrun}, 32'd0);
      check("rst_l0_start", {31'd0, lane0_start}, 32'd0);
      check("rst_rejected", {24'd0, rejected_count}, 32'd0);
      reset = 1'b0;
      tick();

      // ---- 1: three sprites, alternating lanes, cycle by cycle ----
      //          fs    d0    d1    deq   s0    s1    bsy   fd    sel   seq
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
      vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
      vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0};
      vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd1};
      vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
      vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 8'd2};
      vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
      vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
      vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0};
      vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
      push(8'd1); push(8'd2); push(8'd3);
      for (int i = 0; i < 10; i++) begin
         frame_start = vt[i].fs;
         lane0_done  = vt[i].d0;
         lane1_done  = vt[i].d1;
         #1;
         check($sformatf("t1_deq_%0d", i),   {31'd0, dequeue},     {31'd0, vt[i].deq});
         check($sformatf("t1_s0_%0d", i),    {31'd0, lane0_start}, {31'd0, vt[i].s0});
         check($sformatf("t1_s1_%0d", i),    {31'd0, lane1_start}, {31'd0, vt[i].s1});
         check($sformatf("t1_busy_%0d", i),  {31'd0, busy},        {31'd0, vt[i].bsy});
         check($sformatf("t1_fdone_%0d", i), {31'd0, frame_done},  {31'd0, vt[i].fd});
         if (vt[i].s0) begin
            check($sformatf("t1_l0sel_%0d", i), {27'd0, lane0_select}, {24'd0, vt[i].sel});
            check($sformatf("t1_l0seq_%0d", i), {24'd0, lane0_seq},    {24'd0, vt[i].seq});
         end
         if (vt[i].s1) begin
            check($sformatf("t1_l1sel_%0d", i), {27'd0, lane1_select}, {24'd0, vt[i].sel});
            check($sformatf("t1_l1seq_%0d", i), {24'd0, lane1_seq},    {24'd0, vt[i].seq});
         end
         tick();
      end
      check("t1_drawn",    {24'd0, drawn_count}, 32'd3);
      check("t1_l1_x",     {16'd0, lane1_x}, 32'h1002);
      check("t1_l0_y",     {16'd0, lane0_y}, 32'h2003);
      check("t1_l0_scale", {24'd0, lane0_scale}, 32'h59);

      // ---- 2: empty queue, frame_done three cycles after frame_start ----
      frame_start = 1'b1;
      tick();
      check("t2_fd_c1", {31'd0, frame_done}, 32'd0);
      tick();
      check("t2_fd_c2", {31'd0, frame_done}, 32'd0);
      tick();
      check("t2_fd_c3", {31'd0, frame_done}, 32'd1);
      tick();
      check("t2_fd_after", {31'd0, frame_done}, 32'd0);
      check("t2_drawn",    {24'd0, drawn_count}, 32'd0);
      check("t2_idle",     {31'd0, busy}, 32'd0);

      // ---- 3: per-frame cap of 4 with 6 queued ----
      for (int i = 0; i < 6; i++) push(8'(10 + i));
      run_frame(-1);
      check("t3_n", rec_n, 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_seq_%0d", i), {24'd0, rec_seq[i]}, i);
         check($sformatf("t3_sel_%0d", i), {24'd0, rec_sel[i]}, 10 + i);
      end
      check("t3_drawn",     {24'd0, drawn_count}, 32'd4);
      check("t3_not_empty", {31'd0, is_empty}, 32'd0);
      run_frame(-1);
      check("t3b_n", rec_n, 32'd2);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t3b_seq_%0d", i), {24'd0, rec_seq[i]}, i);
         check($sformatf("t3b_sel_%0d", i), {24'd0, rec_sel[i]}, 14 + i);
      end
      check("t3b_drawn",   {24'd0, drawn_count}, 32'd2);
      check("t3_ovr_none", {31'd0, overrun}, 32'd0);

      // ---- 5a: frame_start mid-frame ----
      push(8'd30); push(8'd31); push(8'd7);
      run_frame(2);
      check("t5_overrun", {31'd0, overrun}, 32'd1);
      check("t5_n",       rec_n, 32'd3);
      check("t5_drawn",   {24'd0, drawn_count}, 32'd3);

      // ---- 5b: reset in the middle of FETCH ----
      push(8'd1); push(8'd2); push(8'd3);
      frame_start = 1'b1;
      tick();
      tick();
      saved_qh = qh;
      reset = 1'b1;
      #1;
      check("t5_rst_outs_zero",
            {31'd0, |{dequeue, lane0_start, lane0_select, lane0_x, lane0_y, lane0_scale,
                      lane0_seq, lane1_start, lane1_select, lane1_x, lane1_y, lane1_scale,
                      lane1_seq, busy, frame_done, drawn_count, overrun, rejected_count}},
            32'd0);
      tick();
      reset  = 1'b0;
      fd_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (frame_done) fd_cnt++;
         tick();
      end
      check("t5_no_fdone", fd_cnt, 32'd0);
      check("t5_idle",     {31'd0, busy}, 32'd0);
      check("t5_queue",    qh, saved_qh);
      qh = qt;
      drive_head();

      // ---- 4: lane 0 held busy, rest serial on lane 1 ----
      push(8'd20); push(8'd21); push(8'd22); push(8'd23);
      frame_start = 1'b1;
      tick();
      check("t4_c1_deq", {31'd0, dequeue}, 32'd1);
      tick();
      check("t4_c2_deq",   {31'd0, dequeue}, 32'd1);
      check("t4_c2_s0",    {31'd0, lane0_start}, 32'd1);
      check("t4_c2_l0sel", {27'd0, lane0_select}, 32'd20);
      tick();
      check("t4_c3_deq",   {31'd0, dequeue}, 32'd0);
      check("t4_c3_s1",    {31'd0, lane1_start}, 32'd1);
      check("t4_c3_l1sel", {27'd0, lane1_select}, 32'd21);
      tick();
      lane1_done = 1'b1;
      check("t4_c4_deq_in_done", {31'd0, dequeue}, 32'd0);
      tick();
      check("t4_c5_deq", {31'd0, dequeue}, 32'd1);
      tick();
      check("t4_c6_l1sel", {27'd0, lane1_select}, 32'd22);
      check("t4_c6_l1seq", {24'd0, lane1_seq}, 32'd2);
      check("t4_c6_deq",   {31'd0, dequeue}, 32'd0);
      lane1_done = 1'b1;
      tick();
      check("t4_c7_deq", {31'd0, dequeue}, 32'd1);
      tick();
      check("t4_c8_s1",    {31'd0, lane1_start}, 32'd1);
      check("t4_c8_l1sel", {27'd0, lane1_select}, 32'd23);
      check("t4_c8_l1seq", {24'd0, lane1_seq}, 32'd3);
      check("t4_c8_s0",    {31'd0, lane0_start}, 32'd0);
      lane1_done = 1'b1;
      tick();
      check("t4_drain_busy",  {31'd0, busy}, 32'd1);
      check("t4_drain_fdone", {31'd0, frame_done}, 32'd0);
      check("t4_l0sel_held",  {27'd0, lane0_select}, 32'd20);
      lane0_done = 1'b1;
      tick();
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (frame_done) seen = 1'b1;
         tick();
      end
      check("t4_fdone_seen", {31'd0, seen}, 32'd1);
      check("t4_drawn",      {24'd0, drawn_count}, 32'd4);

      // ---- 6: out-of-range sprite id ----
      push(8'd5); push(8'd40); push(8'd6);
      run_frame(-1);
`ifdef SCHED_ID_CHECK_EN
      check("t6_n",        rec_n, 32'd2);
      check("t6_sel0",     {24'd0, rec_sel[0]}, 32'd5);
      check("t6_sel1",     {24'd0, rec_sel[1]}, 32'd6);
      check("t6_seq1",     {24'd0, rec_seq[1]}, 32'd1);
      check("t6_rejected", {24'd0, rejected_count}, 32'd1);
      check("t6_drawn",    {24'd0, drawn_count}, 32'd2);
`else
      check("t6_n",        rec_n, 32'd3);
      check("t6_sel1",     {24'd0, rec_sel[1]}, 32'd8);
      check("t6_seq2",     {24'd0, rec_seq[2]}, 32'd2);
      check("t6_rejected", {24'd0, rejected_count}, 32'd0);
      check("t6_drawn",    {24'd0, drawn_count}, 32'd3);
`endif
      check("t6_empty", {31'd0, is_empty}, 32'd1);
      push(8'd50);
      run_frame(-1);
`ifdef SCHED_ID_CHECK_EN
      check("t6b_rejected_restart", {24'd0, rejected_count}, 32'd1);
      check("t6b_drawn",            {24'd0, drawn_count}, 32'd0);
`else
      check("t6b_sel",   {24'd0, rec_sel[0]}, 32'd18);
      check("t6b_drawn", {24'd0, drawn_count}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
